// File: rtl/exec_unit_pkg.sv
// Shared types for the execution stage: sequencer states, opcode encoding and shift width.
package exec_unit_pkg;

    typedef enum logic [2:0] {
        SRST   = 3'd0,
        SFETCH = 3'd1,
        SLOAD1 = 3'd2,
        SLOAD2 = 3'd3,
        SCALC  = 3'd4,
        SWRITE = 3'd5,
        SERR   = 3'd6,
        SHALT  = 3'd7
    } SequencerState;

    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpAdd  = 4'd1,
        OpSub  = 4'd2,
        OpAnd  = 4'd3,
        OpOr   = 4'd4,
        OpXor  = 4'd5,
        OpShl  = 4'd6,
        OpShr  = 4'd7,
        OpMov  = 4'd8,
        OpMul  = 4'd9,
        OpDiv  = 4'd10,
        OpHalt = 4'd15
    } ExecOpcode;

    localparam int unsigned ShiftW = 3;

    // Only real operations produce something worth writing back.
    function automatic logic op_writes(input logic [3:0] op);
        return (op != OpNop) && (op != OpHalt);
    endfunction

endpackage

// File: rtl/exec_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// The divider half is only built when EXEC_DIV_EN is defined.
module exec_muldiv
    import exec_unit_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] res_o,
    output logic             hi_nz_o,
    output logic             rem_nz_o
);
    localparam int unsigned CntW = $clog2(Width);
    localparam int unsigned AccW = 2 * Width;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic            busy_q, busy_d;
    logic            active, last;

    // start_i is the first iteration itself, so WIDTH iterations take WIDTH cycles.
    assign active = start_i || busy_q;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        busy_d = busy_q;
        last   = 1'b0;
        if (clr_i) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (active) begin
            last   = (cnt_q == CntW'(Width - 1));
            busy_d = !last;
            cnt_d  = last ? '0 : cnt_q + 1'b1;
            acc_d  = (start_i ? '0 : acc_q) + (b_i[cnt_q] ? (AccW'(a_i) << cnt_q) : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = last;
    assign hi_nz_o = |acc_d[AccW-1:Width];

`ifdef EXEC_DIV_EN
    logic [Width-1:0] quo_q, quo_d, rem_q, rem_d, rem_base, quo_base;
    logic [Width:0]   trial, trial_sub;
    logic [CntW-1:0]  bit_idx;

    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        bit_idx   = CntW'(Width - 1) - cnt_q;
        rem_base  = start_i ? '0 : rem_q;
        quo_base  = start_i ? '0 : quo_q;
        trial     = {rem_base, a_i[bit_idx]};
        trial_sub = trial - {1'b0, b_i};
        if (!clr_i && active) begin
            if (trial >= {1'b0, b_i}) begin
                rem_d = trial_sub[Width-1:0];
                quo_d = {quo_base[Width-2:0], 1'b1};
            end else begin
                rem_d = trial[Width-1:0];
                quo_d = {quo_base[Width-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign res_o    = div_i ? quo_d : acc_d[Width-1:0];
    assign rem_nz_o = |rem_d;
`else
    logic unused_div;
    assign unused_div = div_i;
    assign res_o      = acc_d[Width-1:0];
    assign rem_nz_o   = 1'b0;
`endif

endmodule

// File: rtl/exec_unit.sv
// Execution stage behind the CPU sequencer: latches opcode/operands, runs ALU or MUL/DIV in SCALC.
// Define EXEC_DIV_EN to build the divider; otherwise DIV is decoded as an illegal opcode.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  SequencerState    q,
    input  logic [OPW-1:0]   opcode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             wr_en,
    output logic             nxt_line,
    output logic             finish,
    output logic             err
);
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d, err_q, err_d, done_q, done_d;

    logic             in_calc;
    logic [ShiftW-1:0] sh_amt;
    logic [WIDTH:0]   sum, diff, shl_w, shr_w;
    logic             upd, carry_new;
    logic [WIDTH-1:0] res_new;

    logic             md_run, md_start, md_busy, md_done, md_hi_nz, md_rem_nz, md_div;
    logic [WIDTH-1:0] md_res;

    assign in_calc = (q == SCALC);
    assign sh_amt  = b_q[ShiftW-1:0];
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign diff    = {1'b0, a_q} - {1'b0, b_q};
    // Extra bit on the outgoing side catches the last bit shifted out.
    assign shl_w   = {1'b0, a_q} << sh_amt;
    assign shr_w   = {a_q, 1'b0} >> sh_amt;
    assign md_div  = (opcode_q == OpDiv);
    assign md_start = md_run && !md_busy;

    always_comb begin
        opcode_d  = (q == SLOAD1) ? opcode_in : opcode_q;
        a_d       = (q == SLOAD2) ? a_in : a_q;
        b_d       = (q == SLOAD2) ? b_in : b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        err_d     = err_q;
        done_d    = in_calc ? done_q : 1'b0;
        md_run    = 1'b0;
        upd       = 1'b0;
        res_new   = result_q;
        carry_new = 1'b0;
        if (in_calc && !done_q) begin
            case (opcode_q)
                OpNop: done_d = 1'b1;
                OpAdd: begin upd = 1'b1; res_new = sum[WIDTH-1:0];  carry_new = sum[WIDTH];  end
                OpSub: begin upd = 1'b1; res_new = diff[WIDTH-1:0]; carry_new = diff[WIDTH]; end
                OpAnd: begin upd = 1'b1; res_new = a_q & b_q; end
                OpOr:  begin upd = 1'b1; res_new = a_q | b_q; end
                OpXor: begin upd = 1'b1; res_new = a_q ^ b_q; end
                OpShl: begin upd = 1'b1; res_new = shl_w[WIDTH-1:0]; carry_new = shl_w[WIDTH]; end
                OpShr: begin upd = 1'b1; res_new = shr_w[WIDTH:1];   carry_new = shr_w[0];     end
                OpMov: begin upd = 1'b1; res_new = b_q; end
                OpMul: begin
                    md_run    = 1'b1;
                    upd       = md_done;
                    res_new   = md_res;
                    carry_new = md_hi_nz;
                end
`ifdef EXEC_DIV_EN
                OpDiv: begin
                    if (b_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        md_run    = 1'b1;
                        upd       = md_done;
                        res_new   = md_res;
                        carry_new = md_rem_nz;
                    end
                end
`endif
                OpHalt: begin
                end
                default: err_d = 1'b1;
            endcase
        end
        if (upd) begin
            result_d = res_new;
            zero_d   = (res_new == '0);
            carry_d  = carry_new;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            opcode_q <= OpNop;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    exec_muldiv #(
        .Width(WIDTH)
    ) u_muldiv (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .clr_i   (!in_calc),
        .start_i (md_start),
        .div_i   (md_div),
        .a_i     (a_q),
        .b_i     (b_q),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .res_o   (md_res),
        .hi_nz_o (md_hi_nz),
        .rem_nz_o(md_rem_nz)
    );

    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign err      = err_q;
    assign nxt_line = in_calc && done_q && !err_q;
    assign finish   = in_calc && (opcode_q == OpHalt);
    assign wr_en    = (q == SWRITE) && op_writes(opcode_q);

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus random instruction stream vs an arithmetic model.
module tb_exec_unit;
    import exec_unit_pkg::*;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rstn;
    SequencerState q;
    logic [3:0]    opcode_in;
    logic [7:0]    a_in, b_in, result;
    logic          zero, carry, wr_en, nxt_line, finish, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_res;
    logic       m_zero, m_carry;

    exec_unit #(.WIDTH(W), .OPW(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .q        (q),
        .opcode_in(opcode_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .wr_en    (wr_en),
        .nxt_line (nxt_line),
        .finish   (finish),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Reference behaviour from plain integer arithmetic.
    function automatic void model_exec(input int op, input int a, input int b);
        int sh;
        int p;
        sh = b % 8;
        p  = 0;
        case (op)
            1: begin p = a + b; m_carry = (p > 255); end
            2: begin p = a - b; if (p < 0) p += 256; m_carry = (a < b); end
            3: begin p = a & b; m_carry = 1'b0; end
            4: begin p = a | b; m_carry = 1'b0; end
            5: begin p = a ^ b; m_carry = 1'b0; end
            6: begin p = a * (1 << sh); m_carry = (sh != 0) && (((p >> 8) & 1) == 1); end
            7: begin p = a / (1 << sh); m_carry = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            8: begin p = b; m_carry = 1'b0; end
            9: begin p = a * b; m_carry = (p > 255); end
            10: begin p = a / b; m_carry = ((a % b) != 0); end
            default: return;
        endcase
        m_res  = p[7:0];
        m_zero = (m_res == 8'h00);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        q    = SRST;
        @(negedge clk);
        rstn    = 1'b1;
        m_res   = 8'h00;
        m_zero  = 1'b0;
        m_carry = 1'b0;
    endtask

    // Walks one instruction through SLOAD1/SLOAD2/SCALC and then into 'after'.
    task automatic do_instr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int maxc, input SequencerState after,
                            output int lat, output logic fin1, output logic err2,
                            output logic wr);
        @(negedge clk);
        q         = SLOAD1;
        opcode_in = op;
        a_in      = 8'($urandom);
        b_in      = 8'($urandom);
        @(negedge clk);
        q         = SLOAD2;
        a_in      = a;
        b_in      = b;
        opcode_in = 4'($urandom);
        lat  = 0;
        fin1 = 1'b0;
        err2 = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            q = SCALC;
            #1;
            if (c == 1) fin1 = finish;
            if (c == 2) err2 = err;
            if (nxt_line) begin
                lat = c;
                break;
            end
        end
        @(negedge clk);
        q = after;
        #1;
        wr = wr_en;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        q         = SRST;
        opcode_in = 4'h0;
        a_in      = 8'h00;
        b_in      = 8'h00;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (result !== 8'h00) begin
            n_bad++; $display("FAIL reset.result: got %h want 00", result);
        end
        n_cmp++;
        if ({zero, carry, err, nxt_line, finish, wr_en} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset.flags: got %b want 000000", {zero, carry, err, nxt_line, finish, wr_en});
        end
        m_res = 8'h00; m_zero = 1'b0; m_carry = 1'b0;
    endtask

    task automatic test_add();
        int lat; logic f1, e2, wr;
        do_instr(4'd1, 8'hF0, 8'h20, 12, SWRITE, lat, f1, e2, wr);
        model_exec(1, 'hF0, 'h20);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL add.lat: got %0d want 2", lat); end
        n_cmp++; if (result !== 8'h10) begin n_bad++; $display("FAIL add.result: got %h want 10", result); end
        n_cmp++; if (carry !== 1'b1) begin n_bad++; $display("FAIL add.carry: got %b want 1", carry); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add.zero: got %b want 0", zero); end
        n_cmp++; if (wr !== 1'b1) begin n_bad++; $display("FAIL add.wr_en: got %b want 1", wr); end
    endtask

    task automatic test_mul();
        int lat; logic f1, e2, wr;
        do_instr(4'd9, 8'h12, 8'h03, 12, SWRITE, lat, f1, e2, wr);
        model_exec(9, 'h12, 'h03);
        n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL mul1.lat: got %0d want %0d", lat, W + 1); end
        n_cmp++; if (result !== 8'h36) begin n_bad++; $display("FAIL mul1.result: got %h want 36", result); end
        n_cmp++; if (carry !== 1'b0) begin n_bad++; $display("FAIL mul1.carry: got %b want 0", carry); end
        do_instr(4'd9, 8'h20, 8'h10, 12, SWRITE, lat, f1, e2, wr);
        model_exec(9, 'h20, 'h10);
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL mul2.result: got %h want 00", result); end
        n_cmp++;
        if ({zero, carry} !== 2'b11) begin
            n_bad++; $display("FAIL mul2.zc: got %b want 11", {zero, carry});
        end
    endtask

    task automatic test_div();
        int lat; logic f1, e2, wr;
        logic [7:0] prev;
        prev = m_res;
`ifdef EXEC_DIV_EN
        do_instr(4'd10, 8'h64, 8'h07, 12, SWRITE, lat, f1, e2, wr);
        model_exec(10, 'h64, 'h07);
        n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL div.lat: got %0d want %0d", lat, W + 1); end
        n_cmp++; if (result !== 8'h0E) begin n_bad++; $display("FAIL div.result: got %h want 0e", result); end
        n_cmp++; if (carry !== 1'b1) begin n_bad++; $display("FAIL div.carry: got %b want 1", carry); end
`else
        do_instr(4'd10, 8'h64, 8'h07, 4, SERR, lat, f1, e2, wr);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL div_off.lat: got %0d want 0", lat); end
        n_cmp++; if (e2 !== 1'b1) begin n_bad++; $display("FAIL div_off.err: got %b want 1", e2); end
        n_cmp++; if (result !== prev) begin n_bad++; $display("FAIL div_off.result: got %h want %h", result, prev); end
        apply_reset();
`endif
    endtask

    task automatic test_div_zero();
        int lat; logic f1, e2, wr;
        logic [7:0] prev;
        prev = m_res;
        do_instr(4'd10, 8'h64, 8'h00, 4, SERR, lat, f1, e2, wr);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL divz.nxt_line: got lat %0d want 0", lat); end
        n_cmp++; if (e2 !== 1'b1) begin n_bad++; $display("FAIL divz.err2: got %b want 1", e2); end
        n_cmp++; if (result !== prev) begin n_bad++; $display("FAIL divz.result: got %h want %h", result, prev); end
        repeat (3) @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL divz.err_serr: got %b want 1", err); end
        apply_reset();
    endtask

    task automatic test_halt();
        int lat; logic f1, e2, wr;
        do_instr(4'd1, 8'h21, 8'h12, 12, SWRITE, lat, f1, e2, wr);
        model_exec(1, 'h21, 'h12);
        do_instr(4'hF, 8'($urandom), 8'($urandom), 3, SWRITE, lat, f1, e2, wr);
        n_cmp++; if (f1 !== 1'b1) begin n_bad++; $display("FAIL halt.finish: got %b want 1", f1); end
        n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL halt.wr_en: got %b want 0", wr); end
        n_cmp++; if (result !== m_res) begin n_bad++; $display("FAIL halt.result: got %h want %h", result, m_res); end
        n_cmp++; if (finish !== 1'b0) begin n_bad++; $display("FAIL halt.finish_off: got %b want 0", finish); end
    endtask

    task automatic test_illegal();
        int lat; logic f1, e2, wr;
        do_instr(4'hB, 8'h01, 8'h02, 3, SERR, lat, f1, e2, wr);
        n_cmp++; if (e2 !== 1'b1) begin n_bad++; $display("FAIL ill.err: got %b want 1", e2); end
        do_instr(4'd1, 8'h01, 8'h02, 4, SERR, lat, f1, e2, wr);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL ill.nxt_forced: got lat %0d want 0", lat); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill.sticky: got %b want 1", err); end
        apply_reset();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ill.cleared: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic f1, e2, wr;
        do_instr(4'd1, 8'h05, 8'h03, 12, SWRITE, lat, f1, e2, wr);
        model_exec(1, 5, 3);
        @(negedge clk); q = SLOAD1; opcode_in = 4'd9;
        @(negedge clk); q = SLOAD2; a_in = 8'h12; b_in = 8'h03;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); q = SCALC;
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL rstmul.result: got %h want 00", result); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rstmul.err: got %b want 0", err); end
        n_cmp++; if (nxt_line !== 1'b0) begin n_bad++; $display("FAIL rstmul.nxt_line: got %b want 0", nxt_line); end
        q = SRST;
        m_res = 8'h00; m_zero = 1'b0; m_carry = 1'b0;
        do_instr(4'd1, 8'h33, 8'h44, 12, SWRITE, lat, f1, e2, wr);
        model_exec(1, 'h33, 'h44);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rstmul.add_lat: got %0d want 2", lat); end
        n_cmp++; if (result !== 8'h77) begin n_bad++; $display("FAIL rstmul.add_res: got %h want 77", result); end
    endtask

    task automatic test_back_to_back();
        int lat; logic f1, e2, wr;
        int op, exp_lat;
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 10);
`ifndef EXEC_DIV_EN
            if (op == 10) op = 9;
`endif
            a = 8'($urandom);
            b = 8'($urandom);
            if (op == 10 && b == 8'h00) b = 8'h01;
            model_exec(op, int'(a), int'(b));
            exp_lat = (op == 9 || op == 10) ? W + 1 : 2;
            do_instr(4'(op), a, b, 12, SWRITE, lat, f1, e2, wr);
            n_cmp++;
            if (lat !== exp_lat) begin
                n_bad++; $display("FAIL rand%0d.op%0d.lat: got %0d want %0d", i, op, lat, exp_lat);
            end
            n_cmp++;
            if (result !== m_res) begin
                n_bad++;
                $display("FAIL rand%0d.op%0d.result a=%h b=%h: got %h want %h", i, op, a, b, result, m_res);
            end
            n_cmp++;
            if ({zero, carry} !== {m_zero, m_carry}) begin
                n_bad++;
                $display("FAIL rand%0d.op%0d.zc a=%h b=%h: got %b want %b", i, op, a, b,
                         {zero, carry}, {m_zero, m_carry});
            end
            n_cmp++;
            if (wr !== (op != 0)) begin
                n_bad++; $display("FAIL rand%0d.op%0d.wr_en: got %b want %b", i, op, wr, (op != 0));
            end
            n_cmp++;
            if (err !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d.op%0d.err: got %b want 0", i, op, err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_div_zero();
        test_halt();
        test_illegal();
        test_reset_mid_mul();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
